// File: rtl/spi_shift_unit.sv
// spi_shift_unit: SPDR transmit/receive buffers, serial shift register and
// bit counter sitting beside the SPI controller FSM. Serial timing comes from
// sample/shift tick enables; the controller gates shifting, loading and
// capture through Shifter_en, SPDR_rd_en and SPDR_wr_en.
module spi_shift_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              Shifter_en,
  input  logic              SPDR_rd_en,
  input  logic              SPDR_wr_en,
  input  logic              sample_tick,
  input  logic              shift_tick,
  input  logic              MSTR,
  input  logic              DORD,
  input  logic              miso_in,
  input  logic              mosi_in,
  output logic              mosi_out,
  output logic              miso_out,
  output logic              mosi_oe,
  output logic              miso_oe,
  output logic [2:0]        counter,
  output logic              tx_empty,
  output logic              wcol,
  output logic              byte_done
);

  // Architectural state and its next-state values.
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_buf_q, rx_buf_d;
  logic              in_bit_q, in_bit_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wcol_q, wcol_d;
  logic              byte_done_q, byte_done_d;
  logic              wr_en_dly_q, wr_en_dly_d;

  // Qualified events decoded from the controller and tick inputs.
  logic live_in;
  logic ib;
  logic wr_collide;
  logic wr_accept;
  logic do_load;
  logic do_sample;
  logic do_shift;
  logic capture;
  logic out_bit;

  // Bit presented on the serial output: MSB end or LSB end of the shifter.
  function automatic logic out_sel(input logic [DATA_W-1:0] sr, input logic dord);
    out_sel = dord ? sr[0] : sr[DATA_W-1];
  endfunction

  // One shift step; the new bit enters at the end opposite the output bit.
  function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] sr,
                                                   input logic dord,
                                                   input logic b);
    if (dord)
      shift_step = {b, sr[DATA_W-1:1]};
    else
      shift_step = {sr[DATA_W-2:0], b};
  endfunction

  // Event decode: collisions, load eligibility, sampling, shifting, capture.
  always_comb begin
    live_in    = MSTR ? miso_in : mosi_in;
    // A sample arriving in the same clock as the shift feeds the shifter
    // directly so the bit is not lost waiting for in_bit to update.
    ib         = sample_tick ? live_in : in_bit_q;
    wr_collide = cpu_we & Shifter_en;
    wr_accept  = cpu_we & ~Shifter_en;
    // A CPU write in the same clock takes priority; the load retries later.
    do_load    = SPDR_rd_en & tx_valid_q & ~cpu_we & ~Shifter_en;
    do_sample  = Shifter_en & sample_tick;
    do_shift   = Shifter_en & shift_tick;
    capture    = SPDR_wr_en & ~wr_en_dly_q;
  end

  // Next-state computation for buffers, shifter, counter and flags.
  always_comb begin
    tx_buf_d    = tx_buf_q;
    tx_valid_d  = tx_valid_q;
    shreg_d     = shreg_q;
    rx_buf_d    = rx_buf_q;
    in_bit_d    = in_bit_q;
    cnt_d       = cnt_q;
    wcol_d      = wcol_q;
    byte_done_d = 1'b0;
    wr_en_dly_d = SPDR_wr_en;

    if (wr_accept) begin
      tx_buf_d   = cpu_wdata;
      tx_valid_d = 1'b1;
    end else if (do_load) begin
      tx_valid_d = 1'b0;
    end

    // Load and shift are mutually exclusive: load needs Shifter_en low.
    if (do_load)
      shreg_d = tx_buf_q;
    else if (do_shift)
      shreg_d = shift_step(shreg_q, DORD, ib);

    if (do_sample)
      in_bit_d = live_in;

    // Counter only runs while shifting is enabled; any gap clears it, so a
    // controller that drops Shifter_en mid-byte aborts the count.
    if (!Shifter_en)
      cnt_d = 3'd0;
    else if (shift_tick)
      cnt_d = cnt_q + 3'd1;

    // Set beats clear so a collision racing a status read is not lost.
    if (wr_collide)
      wcol_d = 1'b1;
    else if (cpu_rd)
      wcol_d = 1'b0;

    if (capture) begin
      rx_buf_d    = shreg_q;
      byte_done_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset; reset drops any byte in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf_q    <= '0;
      tx_valid_q  <= 1'b0;
      shreg_q     <= '0;
      rx_buf_q    <= '0;
      in_bit_q    <= 1'b0;
      cnt_q       <= 3'd0;
      wcol_q      <= 1'b0;
      byte_done_q <= 1'b0;
      wr_en_dly_q <= 1'b0;
    end else begin
      tx_buf_q    <= tx_buf_d;
      tx_valid_q  <= tx_valid_d;
      shreg_q     <= shreg_d;
      rx_buf_q    <= rx_buf_d;
      in_bit_q    <= in_bit_d;
      cnt_q       <= cnt_d;
      wcol_q      <= wcol_d;
      byte_done_q <= byte_done_d;
      wr_en_dly_q <= wr_en_dly_d;
    end
  end

  // Output drive: serial pins steered by role, status straight from state.
  always_comb begin
    out_bit   = out_sel(shreg_q, DORD);
    mosi_out  = MSTR & out_bit;
    miso_out  = ~MSTR & out_bit;
    mosi_oe   = MSTR & Shifter_en;
    miso_oe   = ~MSTR & Shifter_en;
    counter   = cnt_q;
    tx_empty  = ~tx_valid_q;
    wcol      = wcol_q;
    byte_done = byte_done_q;
    cpu_rdata = rx_buf_q;
  end

endmodule

// File: doc/spi_shift_unit.md
Name: spi_shift_unit

Overview:
Datapath stage directly downstream of the SPI master/slave controller FSM. It holds the SPDR transmit and receive buffers, the 8-bit serial shift register and the 3-bit bit counter. It consumes Shifter_en, SPDR_rd_en and SPDR_wr_en from the controller and returns the counter value to it. Serial timing comes from sample/shift tick enables produced by the SCK control block.

Parameters:
DATA_W, 8, shift register and buffer width (the counter width is log2(DATA_W); only 8 is supported)

Ports:
clk  input  1  system clock; all registers update on posedge
rst  input  1  reset, asynchronous, active-low
cpu_wdata  input  8  CPU write data for SPDR
cpu_we  input  1  CPU write strobe to SPDR, one clk
cpu_rd  input  1  CPU read strobe of SPDR, one clk; clears wcol
cpu_rdata  output  8  receive buffer contents
Shifter_en  input  1  from controller; shifting allowed
SPDR_rd_en  input  1  from controller; shift register may load from the tx buffer
SPDR_wr_en  input  1  from controller; shift register is copied to the rx buffer
sample_tick  input  1  one-clk pulse; sample the serial input
shift_tick  input  1  one-clk pulse; advance the shift register
MSTR  input  1  1 = master (input is miso_in), 0 = slave (input is mosi_in)
DORD  input  1  0 = MSB first, 1 = LSB first
miso_in  input  1  serial in (master mode)
mosi_in  input  1  serial in (slave mode)
mosi_out  output  1  serial out, master mode
miso_out  output  1  serial out, slave mode
mosi_oe  output  1  MSTR & Shifter_en
miso_oe  output  1  ~MSTR & Shifter_en
counter  output  3  completed shifts mod 8, to controller
tx_empty  output  1  tx buffer holds no pending byte
wcol  output  1  sticky write-collision flag
byte_done  output  1  one-clk pulse when rx buffer is updated

Behaviour:
- Reset (rst=0, async):
  - tx_buf, shreg, rx_buf, in_bit, counter, wcol, byte_done = 0.
  - tx_valid = 0, so tx_empty = 1.
  - wr_en_d (delayed SPDR_wr_en) = 0.
  - Serial outputs = 0.
  - Reset mid-byte abandons the transfer; nothing is retained.
- CPU write:
  - If cpu_we and Shifter_en=1: tx_buf is unchanged and wcol<=1.
  - Else: tx_buf<=cpu_wdata and tx_valid<=1.
- wcol clear and priority:
  - cpu_rd clears wcol.
  - A set in the same cycle as a clear wins.
- Load:
  - If SPDR_rd_en=1, tx_valid=1, cpu_we=0 and Shifter_en=0: shreg<=tx_buf, tx_valid<=0. Latency is 1 clk.
  - If cpu_we occurs in the same cycle, the write wins and the load happens on the next eligible cycle.
  - If tx_valid=0, shreg keeps its last value, so the previous received byte is retransmitted.
- Out bit:
  - out_bit = DORD ? shreg[0] : shreg[7], combinational from shreg.
  - mosi_out = MSTR & out_bit; miso_out = ~MSTR & out_bit.
- Sample:
  - If Shifter_en and sample_tick: in_bit <= (MSTR ? miso_in : mosi_in).
- Shift:
  - If Shifter_en and shift_tick: DORD=0 gives shreg<={shreg[6:0],ib}; DORD=1 gives shreg<={ib,shreg[7:1]}.
  - ib is the live serial input if sample_tick is also high this cycle, else in_bit.
  - counter<=counter+1, wrapping 7 to 0 after 8 shifts.
- Ticks while Shifter_en=0:
  - Ticks are ignored, and counter<=0 every cycle.
  - Shifter_en dropping mid-byte therefore aborts the count; shreg holds its partial value.
- Capture:
  - wr_en_d follows SPDR_wr_en each clk.
  - On the rising edge of SPDR_wr_en (SPDR_wr_en=1, wr_en_d=0): rx_buf<=shreg and byte_done=1 for exactly one clk.
  - A held-high SPDR_wr_en captures only once.
- cpu_rdata = rx_buf at all times; reads have no side effect except clearing wcol.
- DORD and MSTR must be static while Shifter_en=1. A change there is undefined, but must not lock up the block.

Test Plan:
- Reset with rst=0 mid-shift → all outputs 0, tx_empty=1, counter=0; after release, no output toggles without stimulus.
- Master MSB-first: write 0xA5, SPDR_rd_en 1 clk, Shifter_en=1, 8 sample/shift pairs with miso pattern 0x3C, SPDR_wr_en pulse → mosi_out sequence 1,0,1,0,0,1,0,1; counter 1..7 then 0; rx_buf=0x3C; byte_done one clk.
- Slave LSB-first: MSTR=0, DORD=1, write 0x81, mosi pattern 0x5A sent LSB first → miso_out 1,0,0,0,0,0,0,1; miso_oe=1 only while Shifter_en; cpu_rdata=0x5A.
- Collision: cpu_we 0x77 while Shifter_en=1 → wcol=1, tx_buf unchanged; cpu_rd and cpu_we collide in one clk → wcol stays 1; a lone cpu_rd → wcol=0.
- Simultaneous sample_tick and shift_tick every clk → the live input bit lands in shreg in the same cycle; an 8-clk burst yields the correct byte.
- Shifter_en dropped after 3 shifts → counter=0 next clk; SPDR_wr_en held high 5 clks → exactly one byte_done pulse.
